// File: rtl/dedup_pkg.sv
// Shared types and constants for the adjacent-duplicate-collapse stream controller.
package dedup_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int calc_cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dedup_collapse_core.sv
// Combinational collapse of adjacent duplicate bytes in buf_flat[0..len-1],
// packing the surviving bytes in order into res_flat[0..count-1].
module dedup_collapse_core
  import dedup_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = calc_cw(N)
) (
  input  logic [N*BYTE_W-1:0] buf_flat,
  input  logic [CW-1:0]       len,
  output logic [N*BYTE_W-1:0] res_flat,
  output logic [CW-1:0]       count
);

  logic [BYTE_W-1:0] buf_arr [N];
  logic [N-1:0]      keep;
  logic [CW-1:0]     rank [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_keep
      assign buf_arr[gi] = buf_flat[gi*BYTE_W +: BYTE_W];
      if (gi == N - 1) begin : g_tail
        assign keep[gi] = (CW'(gi) < len);
      end else begin : g_body
        // The element at len-1 survives regardless of whatever stale byte follows it.
        assign keep[gi] = (CW'(gi) < len) &&
                          ((CW'(gi + 1) == len) ||
                           (buf_flat[gi*BYTE_W +: BYTE_W] != buf_flat[(gi+1)*BYTE_W +: BYTE_W]));
      end
    end
  endgenerate

  // rank[i] is the output slot an element at index i lands in when kept.
  always_comb begin
    rank[0] = '0;
    for (int i = 1; i < N; i++) begin
      rank[i] = rank[i-1] + CW'(keep[i-1]);
    end
  end

  assign count = rank[N-1] + CW'(keep[N-1]);

  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      logic [BYTE_W-1:0] slot;
      always_comb begin
        slot = '0;
        for (int i = 0; i < N; i++) begin
          if (keep[i] && (rank[i] == CW'(gi))) begin
            slot = buf_arr[i];
          end
        end
      end
      assign res_flat[gi*BYTE_W +: BYTE_W] = slot;
    end
  endgenerate

endmodule

// File: rtl/dedup_stream_ctrl.sv
// Frame loader / collapse / replay controller: buffers an input byte frame,
// collapses adjacent duplicates in one cycle, then drains unique bytes downstream.
module dedup_stream_ctrl
  import dedup_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = calc_cw(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic [CW-1:0]     unique_count,
  output logic              frame_done,
  output logic              busy
);

  localparam int IW = $clog2(N);

  state_t            state_reg;
  logic [CW-1:0]     wr_ptr_reg;
  logic [CW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     len_reg;
  logic [CW-1:0]     unique_count_reg;
  logic [BYTE_W-1:0] buf_mem [N];
  logic [BYTE_W-1:0] res_mem [N];

  logic [N*BYTE_W-1:0] buf_flat;
  logic [N*BYTE_W-1:0] core_res_flat;
  logic [CW-1:0]       core_count;

  logic in_fire;
  logic closing;
  logic out_fire;
  logic last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_flat
      assign buf_flat[gi*BYTE_W +: BYTE_W] = buf_mem[gi];
    end
  endgenerate

  dedup_collapse_core #(
    .N  (N),
    .CW (CW)
  ) u_core (
    .buf_flat (buf_flat),
    .len      (len_reg),
    .res_flat (core_res_flat),
    .count    (core_count)
  );

  assign in_ready  = (state_reg == LOAD);
  assign in_fire   = in_valid && in_ready;
  assign closing   = in_fire && (in_last || (wr_ptr_reg == CW'(N - 1)));
  assign out_valid = (state_reg == DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign last_beat = (rd_ptr_reg == (unique_count_reg - CW'(1)));

  assign out_data     = res_mem[rd_ptr_reg[IW-1:0]];
  assign out_last     = out_valid && last_beat;
  assign unique_count = unique_count_reg;
  // An aborting reset in the same cycle as the final handshake must not report completion.
  assign frame_done   = out_fire && last_beat && !rst;
  assign busy         = !((state_reg == LOAD) && (wr_ptr_reg == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= LOAD;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      len_reg          <= '0;
      unique_count_reg <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (in_fire) begin
            wr_ptr_reg <= wr_ptr_reg + CW'(1);
          end
          if (closing) begin
            len_reg   <= wr_ptr_reg + CW'(1);
            state_reg <= COMPUTE;
          end
        end
        COMPUTE: begin
          unique_count_reg <= core_count;
          rd_ptr_reg       <= '0;
          state_reg        <= DRAIN;
        end
        DRAIN: begin
          if (out_fire) begin
            if (last_beat) begin
              wr_ptr_reg <= '0;
              rd_ptr_reg <= '0;
              state_reg  <= LOAD;
            end else begin
              rd_ptr_reg <= rd_ptr_reg + CW'(1);
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  // Input buffer needs no reset: entries at or beyond len are never observed.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buf_mem[wr_ptr_reg[IW-1:0]] <= in_data;
    end
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_res
      always_ff @(posedge clk) begin
        if (rst) begin
          res_mem[gi] <= '0;
        end else if (state_reg == COMPUTE) begin
          res_mem[gi] <= core_res_flat[gi*BYTE_W +: BYTE_W];
        end
      end
    end
  endgenerate

endmodule
